// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle control sequencer.
// Opcodes, funct codes, ALU ops, pc_src selects and states.
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_LW    = 4'd1;
  localparam logic [3:0] OP_SW    = 4'd2;
  localparam logic [3:0] OP_ADDI  = 4'd3;
  localparam logic [3:0] OP_BEQ   = 4'd4;
  localparam logic [3:0] OP_BNE   = 4'd5;
  localparam logic [3:0] OP_J     = 4'd6;

  localparam logic [3:0] F_ADD = 4'd0;
  localparam logic [3:0] F_SUB = 4'd1;
  localparam logic [3:0] F_SLL = 4'd2;
  localparam logic [3:0] F_AND = 4'd3;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_SLL = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;

  localparam logic [1:0] PC_PLUS2 = 2'b00;
  localparam logic [1:0] PC_BR    = 2'b01;
  localparam logic [1:0] PC_JMP   = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_BRANCH,
    S_JUMP,
    S_TRAP
  } state_t;

endpackage

// File: rtl/alu_op_decoder.sv
// R-type funct to ALU operation decode.
// Flags encodings outside the supported set as illegal.
module alu_op_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 4,
  parameter int ALUOP_W = 4
) (
  input  logic [FUNCT_W-1:0] funct,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               funct_legal
);

  // funct lookup; unknown codes fall back to add but are flagged
  always_comb begin
    alu_op      = ALUOP_W'(ALU_ADD);
    funct_legal = 1'b1;
    unique case (1'b1)
      (funct == FUNCT_W'(F_ADD)): alu_op = ALUOP_W'(ALU_ADD);
      (funct == FUNCT_W'(F_SUB)): alu_op = ALUOP_W'(ALU_SUB);
      (funct == FUNCT_W'(F_SLL)): alu_op = ALUOP_W'(ALU_SLL);
      (funct == FUNCT_W'(F_AND)): alu_op = ALUOP_W'(ALU_AND);
      default:                    funct_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for the 16-bit CPU.
// FETCH/DECODE/EXEC/MEM/WB stepping with memory timeout and traps.
module multicycle_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int OPC_W       = 4,
  parameter int FUNCT_W     = 4,
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OPC_W-1:0]   opcode,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               alu_zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               i_or_d,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               alu_src,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               illegal_op,
  output logic               bus_err,
  output logic               busy
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_q;
  logic               ill_q, bus_q;
  logic               set_ill, set_bus;
  logic [ALUOP_W-1:0] dec_op;
  logic               funct_ok;
  logic               in_mem;
  logic               waiting, timeout;
  logic               is_r, is_lw, is_sw;
  logic               is_addi, is_beq, is_bne, is_j;

  alu_op_decoder #(
    .FUNCT_W(FUNCT_W),
    .ALUOP_W(ALUOP_W)
  ) u_alu_dec (
    .funct      (funct),
    .alu_op     (dec_op),
    .funct_legal(funct_ok)
  );

  assign is_r    = opcode == OPC_W'(OP_RTYPE);
  assign is_lw   = opcode == OPC_W'(OP_LW);
  assign is_sw   = opcode == OPC_W'(OP_SW);
  assign is_addi = opcode == OPC_W'(OP_ADDI);
  assign is_beq  = opcode == OPC_W'(OP_BEQ);
  assign is_bne  = opcode == OPC_W'(OP_BNE);
  assign is_j    = opcode == OPC_W'(OP_J);

  assign in_mem  = (state_q == S_FETCH) || (state_q == S_MEM);
  assign waiting = in_mem && !mem_ready;
  assign timeout = waiting && (wait_q == CNT_W'(MEM_TIMEOUT));

  // state, wait counter and sticky trap flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      ill_q   <= 1'b0;
      bus_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        wait_q <= '0;
      else if (waiting)
        wait_q <= wait_q + CNT_W'(1);
      ill_q <= ill_q | set_ill;
      bus_q <= bus_q | set_bus;
    end
  end

  // next-state selection and trap causes
  always_comb begin
    state_d = state_q;
    set_ill = 1'b0;
    set_bus = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
          set_bus = 1'b1;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          is_r: begin
            state_d = funct_ok ? S_EXEC : S_TRAP;
            set_ill = !funct_ok;
          end
          (is_lw || is_sw || is_addi): state_d = S_EXEC;
          (is_beq || is_bne):          state_d = S_BRANCH;
          is_j:                        state_d = S_JUMP;
          default: begin
            state_d = S_TRAP;
            set_ill = 1'b1;
          end
        endcase
      end
      S_EXEC:   state_d = (is_lw || is_sw) ? S_MEM : S_WB;
      S_MEM: begin
        if (mem_ready) begin
          state_d = is_lw ? S_WB : S_FETCH;
        end else if (timeout) begin
          state_d = S_TRAP;
          set_bus = 1'b1;
        end
      end
      S_WB:     state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
    endcase
  end

  // Moore strobe decode, forced low while reset is held
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_PLUS2;
    alu_op     = ALUOP_W'(ALU_ADD);
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    busy       = state_q != S_TRAP;
    illegal_op = ill_q;
    bus_err    = bus_q;
    unique case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_DECODE: ;
      S_EXEC: begin
        alu_src = !is_r;
        alu_op  = is_r ? dec_op : ALUOP_W'(ALU_ADD);
      end
      S_MEM: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        mem_we  = is_sw;
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_lw;
      end
      S_BRANCH: begin
        alu_op   = ALUOP_W'(ALU_SUB);
        pc_src   = PC_BR;
        pc_write = is_beq ? alu_zero : !alu_zero;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PC_JMP;
      end
      S_TRAP: ;
    endcase
    if (reset) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = PC_PLUS2;
      alu_op     = '0;
      alu_src    = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      busy       = 1'b0;
      illegal_op = 1'b0;
      bus_err    = 1'b0;
    end
  end

endmodule
